vdp_mac_stream: RTL and testbench

Streaming signed dot-product engine for the vdp benchmarks. Consumes K-element vectors g and e, P element pairs per beat, over a valid/ready input. Accumulates in a lane-parallel multiply/adder tree and emits one L-bit dot product per vector on a valid/ready output with a single-entry result buffer. Successor to the single-lane free-running MAC: adds lane parallelism, automatic per-vector clear, vector framing and backpressure.

---
 rtl/vdp_mac_stream.sv | 91 +++++++++
 tb/tb_vdp_mac_stream.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_mac_stream.sv
// Streaming signed dot-product engine: P lanes per beat, K-element vectors, single-entry result buffer.
// Optional build macro VDP_MAC_RELU_EN clamps negative results to zero when the buffer loads.
module vdp_mac_stream #(
    parameter int N = 8,
    parameter int K = 3,
    parameter int P = 1,
    parameter int L = 2*N + $clog2(K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [P*N-1:0] g_input,
    input  logic [P*N-1:0] e_input,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [L-1:0]   out_data,
    output logic [15:0]    vec_cnt
);
    localparam int BEATS = K / P;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = (L > 2*N) ? L : 2*N;

    // Exact 2N-bit product, sign-extended (or wrapped) to the accumulator width.
    function automatic logic signed [L-1:0] lane_prod(input logic signed [N-1:0] a,
                                                      input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        logic signed [WW-1:0]  w;
        p = (2*N)'(a) * (2*N)'(b);
        w = WW'(p);
        return w[L-1:0];
    endfunction

    function automatic logic [L-1:0] relu(input logic signed [L-1:0] s);
`ifdef VDP_MAC_RELU_EN
        return s[L-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    logic signed [L-1:0] beat_sum_p0;
    logic signed [L-1:0] acc_p0;
    logic signed [L-1:0] total_p0;
    logic [BW-1:0]       beat_cnt;
    logic                last_beat;
    logic                accept;
    logic                vld_p1;
    logic [L-1:0]        data_p1;
    logic [15:0]         vcnt;

    // p0: lane products and running vector sum
    always_comb begin
        beat_sum_p0 = '0;
        for (int i = 0; i < P; i++)
            beat_sum_p0 = beat_sum_p0 + lane_prod(g_input[i*N +: N], e_input[i*N +: N]);
    end

    assign last_beat = (beat_cnt == BW'(BEATS-1));
    assign in_ready  = ~(vld_p1 & ~out_ready & last_beat);
    assign accept    = in_valid & in_ready;
    // First beat of a vector ignores the old accumulator, which gives the automatic clear.
    assign total_p0  = ((beat_cnt == '0) ? L'(0) : acc_p0) + beat_sum_p0;

    // p1: single-entry result buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0   <= '0;
            beat_cnt <= '0;
            vld_p1   <= 1'b0;
            data_p1  <= '0;
            vcnt     <= '0;
        end else begin
            if (accept) begin
                acc_p0   <= total_p0;
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            end
            if (accept && last_beat) begin
                vld_p1  <= 1'b1;
                data_p1 <= relu(total_p0);
                vcnt    <= vcnt + 16'd1;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign vec_cnt   = vcnt;
endmodule

// File: tb/tb_vdp_mac_stream.sv
// Bench for vdp_mac_stream: two instances (K=3,P=1 and K=6,P=3) checked every cycle against a vector-level model.
module tb_vdp_mac_stream;
    localparam int K0 = 3, P0 = 1, L0 = 2*8 + $clog2(K0);
    localparam int K1 = 6, P1 = 3, L1 = 2*8 + $clog2(K1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iv[2];
    logic ordy[2];
    logic [23:0] gi[2];
    logic [23:0] ei[2];
    logic rnd_bp[2];

    logic ir0, ir1, ov0, ov1;
    logic [L0-1:0] od0;
    logic [L1-1:0] od1;
    logic [15:0] vc0, vc1;

    always #5 clk = ~clk;

    vdp_mac_stream #(.N(8), .K(K0), .P(P0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .g_input(gi[0][7:0]), .e_input(ei[0][7:0]),
        .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .vec_cnt(vc0));

    vdp_mac_stream #(.N(8), .K(K1), .P(P1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .g_input(gi[1]), .e_input(ei[1]),
        .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .vec_cnt(vc1));

    int n_chk = 0;
    int n_pass = 0;
    int vg[6];
    int ve[6];

    // Model state: collected elements, held result, vector count
    int     mg[2][6];
    int     me[2][6];
    int     mcnt[2];
    bit     mhv[2];
    longint mhd[2];
    int     mvc[2];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int kd(input int d); return (d == 0) ? K0 : K1; endfunction
    function automatic int pd(input int d); return (d == 0) ? P0 : P1; endfunction
    function automatic int ld(input int d); return (d == 0) ? L0 : L1; endfunction

    function automatic longint rl(input longint v);
`ifdef VDP_MAC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic longint wrap(input longint s, input int l);
        longint m, w;
        m = 64'sd1 <<< l;
        w = s & (m - 1);
        if (w >= m / 2) w = w - m;
        return w;
    endfunction

    function automatic int lane(input logic [23:0] v, input int i);
        logic signed [7:0] t;
        t = v[i*8 +: 8];
        return int'(t);
    endfunction

    function automatic longint dod(input int d);
        return (d == 0) ? longint'($signed(od0)) : longint'($signed(od1));
    endfunction

    function automatic bit m_ready(input int d);
        return !(mhv[d] && !ordy[d] && (mcnt[d] == kd(d) - pd(d)));
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; mhv[d] = 0; mhd[d] = 0; mvc[d] = 0;
        end
    endtask

    task automatic m_step(input int d);
        bit take, drain, fin;
        longint s;
        take  = iv[d] && m_ready(d);
        drain = mhv[d] && ordy[d];
        fin   = 0;
        if (take) begin
            for (int i = 0; i < pd(d); i++) begin
                mg[d][mcnt[d] + i] = lane(gi[d], i);
                me[d][mcnt[d] + i] = lane(ei[d], i);
            end
            mcnt[d] += pd(d);
            fin = (mcnt[d] == kd(d));
        end
        if (fin) begin
            s = 0;
            for (int i = 0; i < kd(d); i++) s += longint'(mg[d][i]) * longint'(me[d][i]);
            mhd[d]  = rl(wrap(s, ld(d)));
            mhv[d]  = 1;
            mvc[d]  = (mvc[d] + 1) % 65536;
            mcnt[d] = 0;
        end else if (drain) begin
            mhv[d] = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else for (int d = 0; d < 2; d++) m_step(d);
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("d0_in_ready",  longint'(ir0), longint'(m_ready(0)));
            chk("d0_out_valid", longint'(ov0), longint'(mhv[0]));
            chk("d0_out_data",  dod(0), mhd[0]);
            chk("d0_vec_cnt",   longint'(vc0), longint'(mvc[0]));
            chk("d1_in_ready",  longint'(ir1), longint'(m_ready(1)));
            chk("d1_out_valid", longint'(ov1), longint'(mhv[1]));
            chk("d1_out_data",  dod(1), mhd[1]);
            chk("d1_vec_cnt",   longint'(vc1), longint'(mvc[1]));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) if (rnd_bp[d]) ordy[d] = 1'($urandom_range(0, 1));
        end
    end

    task automatic pin(input int d, input string nm, input longint lit);
        chk({nm, "_model"}, mhd[d], lit);
        chk({nm, "_dut"}, dod(d), lit);
    endtask

    task automatic drive_beat(input int d, input int b);
        logic [23:0] gv, ev;
        gv = '0;
        ev = '0;
        for (int i = 0; i < pd(d); i++) begin
            gv[i*8 +: 8] = 8'(vg[b*pd(d) + i]);
            ev[i*8 +: 8] = 8'(ve[b*pd(d) + i]);
        end
        gi[d] = gv;
        ei[d] = ev;
        iv[d] = 1'b1;
    endtask

    task automatic wait_acc(input int d);
        bit r, done;
        int t;
        done = 0;
        t = 0;
        while (!done) begin
            @(negedge clk);
            r = (d == 0) ? ir0 : ir1;
            @(posedge clk);
            #1;
            if (r) done = 1;
            else if (++t > 200) begin
                n_chk++;
                $display("FAIL handshake_timeout d%0d: in_ready low for %0d cycles, required accept", d, t);
                done = 1;
            end
        end
        iv[d] = 1'b0;
    endtask

    task automatic send_vec(input int d, input int gap);
        for (int b = 0; b < kd(d) / pd(d); b++) begin
            drive_beat(d, b);
            wait_acc(d);
            if (b != kd(d) / pd(d) - 1)
                repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic rand_vecs(input int d, input int n);
        for (int v = 0; v < n; v++) begin
            for (int i = 0; i < 6; i++) begin
                vg[i] = int'($urandom_range(0, 255)) - 128;
                ve[i] = int'($urandom_range(0, 255)) - 128;
            end
            send_vec(d, int'($urandom_range(0, 3)) / 2);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0; ordy[d] = 1; gi[d] = '0; ei[d] = '0; rnd_bp[d] = 0;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(ov0), 0);
        chk("rst_vec_cnt",   longint'(vc0), 0);
        chk("rst_out_data",  dod(0), 0);
        chk("rst_in_ready",  longint'(ir0), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", longint'(ir0), 1);

        vg = '{1, 2, 3, 0, 0, 0}; ve = '{4, 5, 6, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "dot_32", rl(32));
        chk("latency_valid", longint'(ov0), 1);
        @(posedge clk); #1;
        chk("valid_one_cycle", longint'(ov0), 0);
        vg = '{-1, -1, -1, 0, 0, 0}; ve = '{7, 7, 7, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "dot_m21", rl(-21));
        chk("vec_cnt_2", longint'(vc0), 2);

        vg = '{-128, -128, -128, 0, 0, 0}; ve = '{-128, -128, -128, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "ext_pos", rl(49152));
        vg = '{-128, 127, -128, 0, 0, 0}; ve = '{127, -128, 127, 0, 0, 0};
        send_vec(0, 1);
        pin(0, "ext_neg", rl(-48768));
        @(posedge clk); #1;

        ordy[0] = 1'b0;
        vg = '{2, 3, 4, 0, 0, 0}; ve = '{1, 1, 1, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "bp_first", rl(9));
        vg = '{1, 1, 1, 0, 0, 0}; ve = '{5, 6, 7, 0, 0, 0};
        drive_beat(0, 0); wait_acc(0);
        drive_beat(0, 1); wait_acc(0);
        drive_beat(0, 2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_ready", longint'(ir0), 0);
            chk("bp_held_data",   dod(0), rl(9));
            chk("bp_held_valid",  longint'(ov0), 1);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        wait_acc(0);
        pin(0, "bp_reload", rl(18));
        chk("bp_no_bubble", longint'(ov0), 1);
        @(posedge clk); #1;
        chk("bp_drained", longint'(ov0), 0);
        chk("vec_cnt_6", longint'(vc0), 6);

        vg = '{-1, 0, 0, 0, 0, 0}; ve = '{5, 0, 0, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "relu_neg", rl(-5));
        vg = '{1, 0, 0, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "relu_pos", 5);

        vg = '{9, 9, 9, 0, 0, 0}; ve = '{9, 9, 9, 0, 0, 0};
        drive_beat(0, 0); wait_acc(0);
        drive_beat(0, 1); wait_acc(0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid",   longint'(ov0), 0);
        chk("midrst_vec_cnt", longint'(vc0), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        vg = '{1, 1, 1, 0, 0, 0}; ve = '{1, 1, 1, 0, 0, 0};
        send_vec(0, 0);
        pin(0, "after_rst_3", 3);
        chk("after_rst_cnt", longint'(vc0), 1);

        rnd_bp[0] = 1;
        rand_vecs(0, 40);
        rnd_bp[0] = 0;
        ordy[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rand_vec_cnt0", longint'(vc0), 41);

        vg = '{1, 2, 3, 4, 5, 6}; ve = '{2, 2, 2, 2, 2, 2};
        send_vec(1, 3);
        pin(1, "p3_dot_42", 42);
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        vg = '{1, 2, 3, 4, 5, 6}; ve = '{1, 1, 1, 1, 1, 1};
        send_vec(1, 2);
        pin(1, "p3_dot_21", 21);
        vg = '{1, 1, 1, 1, 1, -1}; ve = '{1, 1, 1, 1, 1, 1};
        drive_beat(1, 0); wait_acc(1);
        drive_beat(1, 1);
        @(negedge clk);
        chk("p3_stall_ready", longint'(ir1), 0);
        @(posedge clk); #1;
        ordy[1] = 1'b1;
        wait_acc(1);
        pin(1, "p3_reload_4", 4);
        chk("p3_no_bubble", longint'(ov1), 1);

        rnd_bp[1] = 1;
        rand_vecs(1, 30);
        rnd_bp[1] = 0;
        ordy[1] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("rand_vec_cnt1", longint'(vc1), 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
